// File: rtl/muldiv_e.sv
// Iterative RV32M multiply/divide unit for the EX stage: one radix-2 step per cycle.
// Define MULDIV_DIV_EN to build the divide/remainder datapath; otherwise those ops return 0.
module muldiv_e #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start_e,
  input  logic [2:0]            funct3_e,
  input  logic [DATA_WIDTH-1:0] srca_e,
  input  logic [DATA_WIDTH-1:0] srcb_e,
  output logic                  stall_e,
  output logic                  done_e,
  output logic [DATA_WIDTH-1:0] result_e,
  output logic [1:0]            state_dbg
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2:0]     f3;
  logic           neg;
  logic [W-1:0]   opnd;
  logic [2*W-1:0] p;

  // Operand decode for the op being accepted in IDLE.
  logic         sa_in, sb_in, neg_in;
  logic [W-1:0] mag_a_in, mag_b_in;

  always_comb begin
    if (funct3_e[2]) begin
      sa_in = ~funct3_e[0] & srca_e[W-1];
      sb_in = ~funct3_e[0] & srcb_e[W-1];
    end else begin
      sa_in = (funct3_e[1:0] != 2'b11) & srca_e[W-1];
      sb_in = ~funct3_e[1] & srcb_e[W-1];
    end
    mag_a_in = sa_in ? -srca_e : srca_e;
    mag_b_in = sb_in ? -srcb_e : srcb_e;
    // REM/REMU take the dividend's sign; everything else takes the xor of signs.
    neg_in   = (funct3_e[2] && funct3_e[1]) ? sa_in : (sa_in ^ sb_in);
  end

`ifdef MULDIV_DIV_EN
  logic         b_zero, ovf, special;
  logic [W-1:0] special_res;

  always_comb begin
    b_zero  = (srcb_e == '0);
    ovf     = ~funct3_e[0] && (srca_e == {1'b1, {(W-1){1'b0}}}) && (srcb_e == '1);
    special = funct3_e[2] && (b_zero || ovf);
    if (b_zero) special_res = funct3_e[1] ? srca_e : '1;
    else        special_res = funct3_e[1] ? '0 : srca_e;
  end
`endif

  // One step: p holds {hi, lo}. Multiply adds opnd into hi then shifts right;
  // divide shifts left into the partial remainder and trial-subtracts opnd.
  logic [W-1:0]   addend;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] p_mul, p_next, prod;
  logic [W-1:0]   mul_res, calc_res;

`ifdef MULDIV_DIV_EN
  logic [W:0]     rem_sh, diff;
  logic [2*W-1:0] p_div;
  logic [W-1:0]   div_sel, div_res;
`endif

  always_comb begin
    addend  = p[0] ? opnd : '0;
    mul_sum = {1'b0, p[2*W-1:W]} + {1'b0, addend};
    p_mul   = {mul_sum, p[W-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh  = {p[2*W-1:W], p[W-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (diff[W]) p_div = {rem_sh[W-1:0], p[W-2:0], 1'b0};
    else         p_div = {diff[W-1:0], p[W-2:0], 1'b1};
    p_next  = f3[2] ? p_div : p_mul;
`else
    p_next  = p_mul;
`endif
    prod    = neg ? -p_next : p_next;
    mul_res = (f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
`ifdef MULDIV_DIV_EN
    div_sel  = f3[1] ? p_next[2*W-1:W] : p_next[W-1:0];
    div_res  = neg ? -div_sel : div_sel;
    calc_res = f3[2] ? div_res : mul_res;
`else
    calc_res = f3[2] ? '0 : mul_res;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      f3       <= '0;
      neg      <= 1'b0;
      opnd     <= '0;
      p        <= '0;
      result_e <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_e) begin
            f3  <= funct3_e;
            neg <= neg_in;
            cnt <= '0;
`ifdef MULDIV_DIV_EN
            if (special) begin
              result_e <= special_res;
              state    <= DONE;
            end else begin
              opnd  <= funct3_e[2] ? mag_b_in : mag_a_in;
              p     <= {{W{1'b0}}, (funct3_e[2] ? mag_a_in : mag_b_in)};
              state <= CALC;
            end
`else
            if (funct3_e[2]) begin
              result_e <= '0;
              state    <= DONE;
            end else begin
              opnd  <= mag_a_in;
              p     <= {{W{1'b0}}, mag_b_in};
              state <= CALC;
            end
`endif
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            result_e <= calc_res;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The instruction advances in the DONE cycle, so stall drops there.
  assign stall_e   = start_e && (state != DONE) && !rst;
  assign done_e    = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_e.sv
// Scoreboard bench for muldiv_e: driver pushes reference results, a monitor pops on done_e.
module tb_muldiv_e;

  logic        clk, rst, clr, start_e;
  logic [2:0]  funct3_e;
  logic [31:0] srca_e, srcb_e;
  logic        stall_e, done_e;
  logic [31:0] result_e;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [31:0] hold_val;

  muldiv_e #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start_e(start_e), .funct3_e(funct3_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .stall_e(stall_e), .done_e(done_e),
    .result_e(result_e), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, pr;
    logic [63:0] up;
    logic [31:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    res = '0;
    case (f)
      3'd0: begin pr = sa * sb; res = pr[31:0]; end
      3'd1: begin pr = sa * sb; res = pr[63:32]; end
      3'd2: begin pr = sa * ub; res = pr[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; res = up[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0)                                   res = f[1] ? a : 32'hFFFF_FFFF;
        else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = f[1] ? 32'd0 : a;
        else if (f == 3'd4) begin pr = sa / sb; res = pr[31:0]; end
        else if (f == 3'd6) begin pr = sa % sb; res = pr[31:0]; end
        else if (f == 3'd5) res = a / b;
        else                res = a % b;
`else
        res = 32'd0;
`endif
      end
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 34;
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
`else
    return 2;
`endif
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the op retires.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit seen;
    funct3_e = f; srca_e = a; srcb_e = b; start_e = 1'b1;
    exp_q.push_back(ref_model(f, a, b));
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!stall_e) seen = 1;
    end
    chk($sformatf("latency f3=%0d", f), seen ? cyc : 0, exp_lat(f, a, b));
    @(posedge clk); #1;
    start_e = 1'b0;
  endtask

  // Start an op, then hit it with clr (use_rst=0) or rst (use_rst=1) at CALC step 'step'.
  task automatic abort_op(input bit use_rst, input int step);
    int dones;
    funct3_e = 3'd0; srca_e = 32'd1234; srcb_e = 32'd5678; start_e = 1'b1;
    repeat (step + 1) @(posedge clk);
    #1;
    if (use_rst) begin
      rst = 1'b1;
      #1;
      chk("rst stall_e", {31'b0, stall_e}, 32'd0);
      chk("rst result_e", result_e, 32'd0);
      chk("rst done_e", {31'b0, done_e}, 32'd0);
    end else begin
      clr = 1'b1;
    end
    @(posedge clk); #1;
    if (!use_rst) chk("clr state idle", {30'b0, state_dbg}, 32'd0);
    rst = 1'b0; clr = 1'b0; start_e = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_e) dones++;
    end
    chk(use_rst ? "no done after rst" : "no done after clr", dones, 32'd0);
    chk("idle after abort", {30'b0, state_dbg}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every done_e against the scoreboard and checks result hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pending) begin
        chk("result hold", result_e, hold_val);
        hold_pending = 1'b0;
      end
      if (done_e) begin
        if (exp_q.size() == 0) begin
          chk("unexpected done_e", 32'd1, 32'd0);
        end else begin
          hold_val = exp_q.pop_front();
          chk("result", result_e, hold_val);
          hold_pending = 1'b1;
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; start_e = 1'b1; funct3_e = 3'd0; srca_e = 32'd0; srcb_e = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall_e with start_e", {31'b0, stall_e}, 32'd0);
    chk("reset done_e", {31'b0, done_e}, 32'd0);
    chk("reset result_e", result_e, 32'd0);
    chk("reset state", {30'b0, state_dbg}, 32'd0);
    start_e = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
`ifdef MULDIV_DIV_EN
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd5, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
`else
    issue(3'd4, 32'd9, 32'd3);
    issue(3'd7, 32'd9, 32'd4);
`endif

    abort_op(1'b0, 10);
    issue(3'd0, 32'd3, 32'd4);
    abort_op(1'b1, 5);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rand_opnd();
      b = rand_opnd();
      issue(f, a, b);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
